// File: rtl/formula_pipe_pkg.sv
// Shared types for the sum/max-of-square-roots sequencer and its wrapper.
package formula_pipe_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/formula_sum_isqrt_pipe_fsm_isqrt.sv
// Fixed-latency integer square root: combinational trial-square root feeding a
// LAT-deep delay line, so a root appears exactly LAT cycles after its operand.
module formula_sum_isqrt_pipe_fsm_isqrt #(
  parameter int ARG_W = 32,
  parameter int LAT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [ARG_W-1:0]   x,
  output logic               y_vld,
  output logic [ARG_W/2-1:0] y
);
  localparam int ROOT_W = ARG_W / 2;

  if (LAT < 1) begin : g_lat_check
    $error("isqrt LAT must be at least 1");
  end

  function automatic logic [ROOT_W-1:0] isqrt_f(input logic [ARG_W-1:0] v);
    logic [ROOT_W-1:0] root;
    logic [ROOT_W-1:0] trial;
    root = '0;
    for (int b = ROOT_W - 1; b >= 0; b--) begin
      trial = root | (ROOT_W'(1) << b);
      if (ARG_W'(trial) * ARG_W'(trial) <= v) root = trial;
    end
    return root;
  endfunction

  logic [LAT-1:0]    vld_q, vld_d;
  logic [ROOT_W-1:0] y_q [LAT];
  logic [ROOT_W-1:0] y_d [LAT];

  always_comb begin
    vld_d[0] = x_vld;
    y_d[0]   = isqrt_f(x);
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      y_d[i]   = y_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    y_q <= y_d;
  end

  assign y_vld = vld_q[LAT-1];
  assign y     = y_q[LAT-1];

endmodule

// File: rtl/formula_sum_isqrt_pipe_fsm_top.sv
// Self-contained wrapper pairing the sequencer with a matching-latency isqrt.
module formula_sum_isqrt_pipe_fsm_top
  import formula_pipe_pkg::*;
#(
  parameter int N_ARGS    = 3,
  parameter int ARG_W     = 32,
  parameter int RES_W     = 32,
  parameter int ISQRT_LAT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arg_vld,
  output logic                    arg_rdy,
  input  logic                    mode,
  input  logic [N_ARGS*ARG_W-1:0] args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res
);
  logic               x_vld;
  logic [ARG_W-1:0]   x;
  logic               y_vld;
  logic [ARG_W/2-1:0] y;

  formula_sum_isqrt_pipe_fsm #(
    .N_ARGS   (N_ARGS),
    .ARG_W    (ARG_W),
    .RES_W    (RES_W),
    .ISQRT_LAT(ISQRT_LAT)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .arg_vld    (arg_vld),
    .arg_rdy    (arg_rdy),
    .mode       (mode),
    .args       (args),
    .res_vld    (res_vld),
    .res        (res),
    .isqrt_x_vld(x_vld),
    .isqrt_x    (x),
    .isqrt_y_vld(y_vld),
    .isqrt_y    (y)
  );

  formula_sum_isqrt_pipe_fsm_isqrt #(
    .ARG_W(ARG_W),
    .LAT  (ISQRT_LAT)
  ) u_isqrt (
    .clk  (clk),
    .rst_n(rst_n),
    .x_vld(x_vld),
    .x    (x),
    .y_vld(y_vld),
    .y    (y)
  );

endmodule

// File: rtl/formula_sum_isqrt_pipe_fsm.sv
// Sequencer that streams N_ARGS operands into an external pipelined isqrt and
// folds the returning roots into a sum or a maximum.
module formula_sum_isqrt_pipe_fsm
  import formula_pipe_pkg::*;
#(
  parameter int N_ARGS    = 3,
  parameter int ARG_W     = 32,
  parameter int RES_W     = 32,
  parameter int ISQRT_LAT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arg_vld,
  output logic                    arg_rdy,
  input  logic                    mode,
  input  logic [N_ARGS*ARG_W-1:0] args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res,
  output logic                    isqrt_x_vld,
  output logic [ARG_W-1:0]        isqrt_x,
  input  logic                    isqrt_y_vld,
  input  logic [ARG_W/2-1:0]      isqrt_y
);
  localparam int ROOT_W    = ARG_W / 2;
  localparam int CNT_W     = cnt_w(N_ARGS);
  localparam int FL_W      = cnt_w(ISQRT_LAT);
  localparam int MIN_RES_W = ROOT_W + $clog2(N_ARGS);

  if (RES_W < MIN_RES_W) begin : g_res_w_check
    $error("RES_W=%0d is below the overflow-free minimum %0d", RES_W, MIN_RES_W);
  end
  if (N_ARGS < 1 || N_ARGS > 16) begin : g_n_args_check
    $error("N_ARGS=%0d outside 1..16", N_ARGS);
  end
  if (ARG_W < 2 || ARG_W > 32 || (ARG_W % 2) != 0) begin : g_arg_w_check
    $error("ARG_W=%0d must be even and within 2..32", ARG_W);
  end

  function automatic logic [RES_W-1:0] acc_update(input logic [RES_W-1:0] acc,
                                                  input logic [ROOT_W-1:0] root,
                                                  input mode_e m);
    logic [RES_W-1:0] r;
    r = RES_W'(root);
    if (m == MODE_MAX) return (r > acc) ? r : acc;
    return acc + r;
  endfunction

  state_e                  state_q, state_d;
  logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
  logic [RES_W-1:0]        acc_q, acc_d;
  logic [RES_W-1:0]        res_q, res_d;
  logic                    res_vld_q, res_vld_d;
  logic [N_ARGS*ARG_W-1:0] args_q, args_d;
  mode_e                   mode_q, mode_d;
  logic                    absorb;
  logic [RES_W-1:0]        acc_upd;

  // Roots are only meaningful while a transaction is in flight; anything
  // surfacing in FLUSH/IDLE or beyond the N_ARGS-th root is a stale leftover.
  assign absorb  = isqrt_y_vld && (state_q == ST_ISSUE || state_q == ST_WAIT)
                   && (recv_cnt_q < CNT_W'(N_ARGS));
  assign acc_upd = acc_update(acc_q, isqrt_y, mode_q);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_vld_d   = 1'b0;
    args_d      = args_q;
    mode_d      = mode_q;
    arg_rdy     = 1'b0;
    isqrt_x_vld = 1'b0;
    isqrt_x     = args_q[ARG_W-1:0];
    for (int k = 0; k < N_ARGS; k++) begin
      if (issue_cnt_q == CNT_W'(k)) isqrt_x = args_q[k*ARG_W +: ARG_W];
    end

    unique case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q <= FL_W'(1)) state_d = ST_IDLE;
        else flush_cnt_d = flush_cnt_q - FL_W'(1);
      end
      ST_IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          args_d      = args;
          mode_d      = mode_e'(mode);
          acc_d       = '0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        isqrt_x_vld = 1'b1;
        if (issue_cnt_q == CNT_W'(N_ARGS - 1)) begin
          issue_cnt_d = '0;
          state_d     = ST_WAIT;
        end else begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: ;
      default: state_d = ST_FLUSH;
    endcase

    // Completion is driven purely by the root count, so any isqrt latency works.
    if (absorb) begin
      recv_cnt_d = recv_cnt_q + CNT_W'(1);
      acc_d      = acc_upd;
      if (recv_cnt_q == CNT_W'(N_ARGS - 1)) begin
        res_d     = acc_upd;
        res_vld_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= FL_W'(ISQRT_LAT);
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_vld_q   <= res_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    args_q <= args_d;
    mode_q <= mode_d;
  end

  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

// File: tb/tb_formula_sum_isqrt_pipe_fsm.sv
// Directed bench: two bare sequencers driven by behavioural isqrt delay lines,
// plus the wrapper with its own isqrt.
module tb_formula_sum_isqrt_pipe_fsm;
  localparam int L  = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // N_ARGS=3, ARG_W=32, RES_W=32
  logic        a_vld, a_rdy, a_mode, a_rvld, a_xv, a_yv;
  logic [95:0] a_args;
  logic [31:0] a_res, a_x;
  logic [15:0] a_y;
  // N_ARGS=5, ARG_W=16, RES_W=11
  logic        b_vld, b_rdy, b_mode, b_rvld, b_xv, b_yv;
  logic [79:0] b_args;
  logic [10:0] b_res;
  logic [15:0] b_x;
  logic [7:0]  b_y;
  // wrapper
  logic        c_vld, c_rdy, c_mode, c_rvld;
  logic [95:0] c_args;
  logic [31:0] c_res;

  function automatic longint isqrt_ref(input longint x);
    longint r;
    longint t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  formula_sum_isqrt_pipe_fsm #(.N_ARGS(3), .ARG_W(32), .RES_W(32), .ISQRT_LAT(L)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .arg_vld(a_vld), .arg_rdy(a_rdy), .mode(a_mode),
    .args(a_args), .res_vld(a_rvld), .res(a_res), .isqrt_x_vld(a_xv),
    .isqrt_x(a_x), .isqrt_y_vld(a_yv), .isqrt_y(a_y));

  formula_sum_isqrt_pipe_fsm #(.N_ARGS(5), .ARG_W(16), .RES_W(11), .ISQRT_LAT(L)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .arg_vld(b_vld), .arg_rdy(b_rdy), .mode(b_mode),
    .args(b_args), .res_vld(b_rvld), .res(b_res), .isqrt_x_vld(b_xv),
    .isqrt_x(b_x), .isqrt_y_vld(b_yv), .isqrt_y(b_y));

  formula_sum_isqrt_pipe_fsm_top #(.N_ARGS(3), .ARG_W(32), .RES_W(32), .ISQRT_LAT(LW)) u_top (
    .clk(clk), .rst_n(rst_n), .arg_vld(c_vld), .arg_rdy(c_rdy), .mode(c_mode),
    .args(c_args), .res_vld(c_rvld), .res(c_res));

  // Behavioural isqrt models: fixed L-cycle delay, deliberately not reset so
  // in-flight roots keep draining across a reset.
  logic [L-1:0] a_vp = '0;
  logic [15:0]  a_rp [L];
  logic [L-1:0] b_vp = '0;
  logic [7:0]   b_rp [L];

  always @(posedge clk) begin
    a_vp    <= {a_vp[L-2:0], a_xv};
    a_rp[0] <= 16'(isqrt_ref(longint'(a_x)));
    b_vp    <= {b_vp[L-2:0], b_xv};
    b_rp[0] <= 8'(isqrt_ref(longint'(b_x)));
    for (int i = 1; i < L; i++) begin
      a_rp[i] <= a_rp[i-1];
      b_rp[i] <= b_rp[i-1];
    end
  end
  assign a_yv = a_vp[L-1];
  assign a_y  = a_rp[L-1];
  assign b_yv = b_vp[L-1];
  assign b_y  = b_rp[L-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run3(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] x2, input logic m, input longint exp);
    int n;
    n = 0;
    while (!a_rdy && n < 200) begin tick(); n++; end
    check({tag, "_rdy"}, longint'(a_rdy), 1);
    a_args = {x2, x1, x0};
    a_mode = m;
    a_vld  = 1'b1;
    tick();
    a_vld = 1'b0;
    check({tag, "_x0"}, longint'({a_xv, a_x}), longint'({1'b1, x0}));
    tick();
    check({tag, "_x1"}, longint'({a_xv, a_x}), longint'({1'b1, x1}));
    tick();
    check({tag, "_x2"}, longint'({a_xv, a_x}), longint'({1'b1, x2}));
    tick();
    check({tag, "_xoff"}, longint'(a_xv), 0);
    n = 4;
    while (!a_rvld && n < 200) begin tick(); n++; end
    check({tag, "_lat"}, n, L + 4);
    check({tag, "_res"}, longint'(a_res), exp);
    tick();
    check({tag, "_pulse"}, longint'(a_rvld), 0);
    check({tag, "_hold"}, longint'(a_res), exp);
  endtask

  task automatic run5(input string tag, input logic m, input longint exp);
    int n;
    int extra;
    n = 0;
    while (!b_rdy && n < 200) begin tick(); n++; end
    check({tag, "_rdy"}, longint'(b_rdy), 1);
    b_args = {16'd255, 16'd3, 16'd2, 16'd1, 16'd0};
    b_mode = m;
    b_vld  = 1'b1;
    tick();
    b_vld = 1'b0;
    tick();
    tick();
    // offered while busy: must be ignored
    b_args = {5{16'hFFFF}};
    b_mode = ~m;
    b_vld  = 1'b1;
    check({tag, "_busy_rdy"}, longint'(b_rdy), 0);
    tick();
    b_vld = 1'b0;
    n = 4;
    while (!b_rvld && n < 200) begin tick(); n++; end
    check({tag, "_lat"}, n, L + 6);
    check({tag, "_res"}, longint'(b_res), exp);
    extra = 0;
    for (int i = 0; i < 2 * (L + 6); i++) begin
      tick();
      if (b_rvld) extra++;
    end
    check({tag, "_no_extra"}, extra, 0);
    check({tag, "_hold"}, longint'(b_res), exp);
  endtask

  task automatic runw(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] x2, input logic m, input longint exp);
    int n;
    n = 0;
    while (!c_rdy && n < 200) begin tick(); n++; end
    check({tag, "_rdy"}, longint'(c_rdy), 1);
    c_args = {x2, x1, x0};
    c_mode = m;
    c_vld  = 1'b1;
    tick();
    c_vld = 1'b0;
    n = 1;
    while (!c_rvld && n < 200) begin tick(); n++; end
    check({tag, "_lat"}, n, LW + 4);
    check({tag, "_res"}, longint'(c_res), exp);
    tick();
    check({tag, "_pulse"}, longint'(c_rvld), 0);
  endtask

  initial begin
    longint      expq[$];
    longint      r0, r1, r2, e;
    logic [31:0] x0, x1, x2;
    int          n, sent, got, last, cyc, seen;

    rst_n = 1'b0;
    a_vld = 1'b0; a_mode = 1'b0; a_args = '0;
    b_vld = 1'b0; b_mode = 1'b0; b_args = '0;
    c_vld = 1'b0; c_mode = 1'b0; c_args = '0;
    tick(); tick(); tick();
    check("rst_rdy", longint'(a_rdy), 0);
    check("rst_res_vld", longint'(a_rvld), 0);
    check("rst_res", longint'(a_res), 0);
    check("rst_xvld", longint'(a_xv), 0);
    check("rst_res5", longint'(b_res), 0);
    rst_n = 1'b1;
    n = 0;
    while (!a_rdy && n < 200) begin tick(); n++; end
    check("flush_len", n, L);

    run3("sum_149", 32'd1, 32'd4, 32'd9, 1'b0, 6);
    run3("max_149", 32'd1, 32'd4, 32'd9, 1'b1, 3);
    run3("max_000", 32'd0, 32'd0, 32'd0, 1'b1, 0);
    run3("sum_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 196605);

    // back-to-back with arg_vld held high
    sent = 0; got = 0; last = 0; cyc = 0;
    a_vld = 1'b1;
    while (got < 100 && cyc < 100 * (L + 4) + 300) begin
      if (a_rvld) begin
        if (expq.size() > 0) check("b2b_res", longint'(a_res), expq.pop_front());
        else check("b2b_spurious", 1, 0);
        got++;
      end
      if (a_rdy && sent < 100) begin
        if (sent > 0) check("b2b_gap", cyc - last, L + 4);
        last = cyc;
        x0 = 32'(sent * sent);
        x1 = 32'hFFFF_FFFF - 32'(sent * 1000);
        x2 = 32'(sent * 12345 + 1);
        r0 = isqrt_ref(longint'(x0));
        r1 = isqrt_ref(longint'(x1));
        r2 = isqrt_ref(longint'(x2));
        a_mode = sent[0];
        if (sent[0]) begin
          e = r0;
          if (r1 > e) e = r1;
          if (r2 > e) e = r2;
        end else begin
          e = r0 + r1 + r2;
        end
        expq.push_back(e);
        a_args = {x2, x1, x0};
        sent++;
      end else if (sent == 100) begin
        a_vld = 1'b0;
      end
      tick();
      cyc++;
    end
    a_vld = 1'b0;
    check("b2b_count", got, 100);

    // reset while roots are in flight
    n = 0;
    while (!a_rdy && n < 200) begin tick(); n++; end
    a_args = {32'd100, 32'd100, 32'd100};
    a_mode = 1'b0;
    a_vld  = 1'b1;
    tick();
    a_vld = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_rdy", longint'(a_rdy), 0);
    check("mid_rst_res_vld", longint'(a_rvld), 0);
    check("mid_rst_res", longint'(a_res), 0);
    rst_n = 1'b1;
    n = 0; seen = 0;
    while (!a_rdy && n < 200) begin
      if (a_rvld) seen++;
      tick();
      n++;
    end
    check("mid_rst_flush", n, L);
    check("mid_rst_no_res", seen, 0);
    run3("post_rst", 32'd2, 32'd3, 32'd5, 1'b0, 4);

    run5("n5_sum", 1'b0, 18);
    run5("n5_max", 1'b1, 15);

    runw("top_sum", 32'd1, 32'd4, 32'd9, 1'b0, 6);
    runw("top_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 196605);
    runw("top_max", 32'd16, 32'd25, 32'd9, 1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
